// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives a 1-cycle-latency instruction ROM, buffers returned words
// with their PCs in a small FIFO and hands them to the core over valid/ready.
// Redirects flush everything in flight; halt only stops new reads.
module instr_fetch_unit #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [OCC_W-1:0]  DEPTH_OCC  = OCC_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];

  logic              fifo_nonempty;
  logic              pop;
  logic              push;
  logic [OCC_W-1:0]  occupancy;

  // Handshake, issue decision and head presentation; the head is zeroed while empty
  always_comb begin
    fifo_nonempty = (count_q != '0);
    pop           = fifo_nonempty && instr_ready;
    push          = inflight_q && !redirect_valid;
    occupancy     = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    rom_rd_en     = rst_n && !halt && !redirect_valid && (occupancy < DEPTH_OCC);
    rom_addr      = fetch_pc_q;
    instr_valid   = fifo_nonempty;
    instr         = fifo_nonempty ? data_mem_q[rd_ptr_q] : '0;
    instr_pc      = fifo_nonempty ? pc_mem_q[rd_ptr_q] : '0;
  end

  // Next state: a redirect wins over pop, the returning word and halt
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = rom_rd_en;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    data_mem_d    = data_mem_q;
    pc_mem_d      = pc_mem_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (rom_rd_en) begin
        fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        data_mem_d[wr_ptr_q] = rom_data;
        pc_mem_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state with synchronous reset; clearing inflight discards any late ROM word
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage needs no reset since count gates every read of it
  always_ff @(posedge CLOCK_50) begin
    data_mem_q <= data_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

endmodule
